// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings.
// Transfer types and response codes used by bus slaves.
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb3lite_fault_log.sv
// Fault capture block: last faulting transfer,
// saturating counter, sticky irq/overflow.
module ahb3lite_fault_log #(
  parameter int HADDR_SIZE = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  log_stb,
  input  logic [HADDR_SIZE-1:0] log_addr,
  input  logic                  log_write,
  input  logic [2:0]            log_size,
  input  logic                  fault_clr,
  output logic                  fault_valid,
  output logic [HADDR_SIZE-1:0] fault_addr,
  output logic                  fault_write,
  output logic [2:0]            fault_size,
  output logic [CNT_WIDTH-1:0]  fault_count,
  output logic                  fault_ovf,
  output logic                  irq
);
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_write <= 1'b0;
      fault_size  <= 3'd0;
      fault_count <= '0;
      fault_ovf   <= 1'b0;
      irq         <= 1'b0;
    end else begin
      fault_valid <= log_stb;
      if (log_stb) begin
        fault_addr  <= log_addr;
        fault_write <= log_write;
        fault_size  <= log_size;
        irq         <= 1'b1;
        // a clear racing a new fault restarts the log at this fault
        if (fault_clr) begin
          fault_count <= CNT_WIDTH'(1);
          fault_ovf   <= 1'b0;
        end else begin
          if (fault_count != '1)
            fault_count <= fault_count + CNT_WIDTH'(1);
          if (irq)
            fault_ovf <= 1'b1;
        end
      end else if (fault_clr) begin
        fault_count <= '0;
        fault_ovf   <= 1'b0;
        irq         <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ahb3lite_fault_slave.sv
// AHB3-Lite default slave: ERROR or OKAY response
// after optional wait states, with fault logging.
module ahb3lite_fault_slave
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int WAIT_STATES = 0,
  parameter int RESP_MODE   = 1,
  parameter logic [HDATA_SIZE-1:0] RDATA_FILL = '0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  fault_clr,
  output logic                  fault_valid,
  output logic [HADDR_SIZE-1:0] fault_addr,
  output logic                  fault_write,
  output logic [2:0]            fault_size,
  output logic [CNT_WIDTH-1:0]  fault_count,
  output logic                  fault_ovf,
  output logic                  irq
);
  typedef enum logic [1:0] {
    ST_IDLE, ST_WAIT, ST_RESP1, ST_RESP2
  } state_t;

  localparam bit ERR_MODE = (RESP_MODE != 0);
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] WLOAD =
    HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_t ST_FIRST =
    ERR_MODE ? ST_RESP1 : ST_RESP2;

  state_t                state;
  logic [3:0]            wcnt;
  logic [HADDR_SIZE-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;

  logic accept;
  logic open_ph;
  logic take;
  logic log_stb;

  assign accept = HSEL & HREADY &
    ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign open_ph = (state == ST_IDLE) | (state == ST_RESP2);
  assign take = accept & open_ph;
  assign log_stb = (take & !HAS_WAIT) |
    ((state == ST_WAIT) & (wcnt == 4'd0));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= ST_IDLE;
      wcnt    <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      unique case (state)
        ST_IDLE, ST_RESP2: begin
          if (take) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            size_q  <= HSIZE;
            if (HAS_WAIT) begin
              state <= ST_WAIT;
              wcnt  <= WLOAD;
            end else begin
              state <= ST_FIRST;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (wcnt == 4'd0)
            state <= ST_FIRST;
          else
            wcnt <= wcnt - 4'd1;
        end
        ST_RESP1: state <= ST_RESP2;
      endcase
    end
  end

  assign HREADYOUT = open_ph;
  assign HRESP =
    ((state == ST_RESP1) | ((state == ST_RESP2) & ERR_MODE))
      ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA = RDATA_FILL;

  // zero-wait faults log straight from the live address phase
  ahb3lite_fault_log #(
    .HADDR_SIZE (HADDR_SIZE),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_log (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .log_stb     (log_stb),
    .log_addr    (take ? HADDR : addr_q),
    .log_write   (take ? HWRITE : write_q),
    .log_size    (take ? HSIZE : size_q),
    .fault_clr   (fault_clr),
    .fault_valid (fault_valid),
    .fault_addr  (fault_addr),
    .fault_write (fault_write),
    .fault_size  (fault_size),
    .fault_count (fault_count),
    .fault_ovf   (fault_ovf),
    .irq         (irq)
  );
endmodule
